// File: rtl/ram_dump_reader_if.sv
// Bus bundle between the dump reader, the data RAM read port and the
// downstream pixel consumer.
interface ram_dump_reader_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              pix_ready;
   logic              pix_last;

   // reader side: drives the RAM address and the pixel stream
   modport master (
      output mem_addr, mem_rd_en, pix_data, pix_valid, pix_last,
      input  mem_data, pix_ready
   );

   // RAM + consumer side
   modport slave (
      input  mem_addr, mem_rd_en, pix_data, pix_valid, pix_last,
      output mem_data, pix_ready
   );
endinterface

// File: rtl/ram_dump_reader.sv
// Streams the result image out of the processor data RAM in row-major
// order once the processor signals completion. One RAM read per word,
// address built incrementally (row_base += WIDTH) so no multiplier is needed.
module ram_dump_reader #(
   parameter int WIDTH  = 100,
   parameter int HEIGHT = 100,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_dump,
   ram_dump_reader_if.master    bus,
   output logic                 busy,
   output logic                 dump_done
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ISSUE  = 3'd1;
   localparam logic [2:0] WAIT   = 3'd2;
   localparam logic [2:0] OUT    = 3'd3;
   localparam logic [2:0] FINISH = 3'd4;

   localparam int I_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int J_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2:0]        state_reg;
   logic [I_W-1:0]    i_reg;
   logic [J_W-1:0]    j_reg;
   logic [ADDR_W-1:0] row_base_reg;
   logic              last_pos;
   logic              row_end;

   assign row_end  = (j_reg == J_W'(WIDTH - 1));
   assign last_pos = (i_reg == I_W'(HEIGHT - 1)) && row_end;

   // Scan FSM: ISSUE presents the address, WAIT lets the RAM respond,
   // OUT holds the word until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         i_reg         <= '0;
         j_reg         <= '0;
         row_base_reg  <= '0;
         bus.mem_addr  <= '0;
         bus.mem_rd_en <= 1'b0;
         bus.pix_data  <= '0;
         bus.pix_valid <= 1'b0;
         bus.pix_last  <= 1'b0;
         busy          <= 1'b0;
         dump_done     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_dump) begin
                  i_reg         <= '0;
                  j_reg         <= '0;
                  row_base_reg  <= '0;
                  bus.mem_addr  <= '0;
                  bus.mem_rd_en <= 1'b1;
                  busy          <= 1'b1;
                  state_reg     <= ISSUE;
               end
            end
            ISSUE: begin
               bus.mem_rd_en <= 1'b0;
               state_reg     <= WAIT;
            end
            WAIT: begin
               bus.pix_data  <= bus.mem_data;
               bus.pix_last  <= last_pos;
               bus.pix_valid <= 1'b1;
               state_reg     <= OUT;
            end
            OUT: begin
               if (bus.pix_ready) begin
                  bus.pix_valid <= 1'b0;
                  bus.pix_last  <= 1'b0;
                  if (bus.pix_last) begin
                     dump_done <= 1'b1;
                     state_reg <= FINISH;
                  end else if (row_end) begin
                     // wrap to the next row: the next address is the new row base
                     j_reg         <= '0;
                     i_reg         <= i_reg + 1'b1;
                     row_base_reg  <= row_base_reg + ADDR_W'(WIDTH);
                     bus.mem_addr  <= row_base_reg + ADDR_W'(WIDTH);
                     bus.mem_rd_en <= 1'b1;
                     state_reg     <= ISSUE;
                  end else begin
                     j_reg         <= j_reg + 1'b1;
                     bus.mem_addr  <= row_base_reg + ADDR_W'(j_reg) + ADDR_W'(1);
                     bus.mem_rd_en <= 1'b1;
                     state_reg     <= ISSUE;
                  end
               end
            end
            FINISH: begin
               dump_done <= 1'b0;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               bus.mem_rd_en <= 1'b0;
               bus.pix_valid <= 1'b0;
               bus.pix_last  <= 1'b0;
               dump_done     <= 1'b0;
               busy          <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench: a 4x3 reader for the detailed scenarios and a 100x100
// reader for the default geometry, each with a one-cycle-latency RAM model.
module tb_ram_dump_reader;
   logic clk;
   logic rst;
   logic start_s, start_b;
   logic busy_s, done_s, busy_b, done_b;
   int   tests_run;
   int   tests_failed;

   ram_dump_reader_if #(.ADDR_W(14), .DATA_W(32)) sb ();
   ram_dump_reader_if #(.ADDR_W(14), .DATA_W(32)) bb ();

   ram_dump_reader #(.WIDTH(4), .HEIGHT(3), .ADDR_W(14), .DATA_W(32)) dut_s (
      .clk(clk), .rst(rst), .start_dump(start_s), .bus(sb),
      .busy(busy_s), .dump_done(done_s)
   );

   ram_dump_reader #(.WIDTH(100), .HEIGHT(100), .ADDR_W(14), .DATA_W(32)) dut_b (
      .clk(clk), .rst(rst), .start_dump(start_b), .bus(bb),
      .busy(busy_b), .dump_done(done_b)
   );

   always #5 clk = ~clk;

   // small RAM: word[a] = a + 0x100
   always @(posedge clk) begin
      if (sb.mem_rd_en) sb.mem_data <= 32'h100 + 32'(sb.mem_addr);
   end

   // large RAM: marker at 4207, otherwise a tagged address
   always @(posedge clk) begin
      if (bb.mem_rd_en)
         bb.mem_data <= (bb.mem_addr == 14'd4207) ? 32'hDEADBEEF : (32'h5000_0000 | 32'(bb.mem_addr));
   end

   task automatic test_reset();
      #1;
      tests_run++;
      if (sb.mem_addr !== 14'd0 || sb.mem_rd_en !== 1'b0) begin
         tests_failed++; $display("FAIL reset_mem: got addr=%0h rd=%0b expected 0/0", sb.mem_addr, sb.mem_rd_en);
      end
      tests_run++;
      if (sb.pix_data !== 32'd0 || sb.pix_valid !== 1'b0 || sb.pix_last !== 1'b0) begin
         tests_failed++; $display("FAIL reset_pix: got data=%0h v=%0b l=%0b expected 0", sb.pix_data, sb.pix_valid, sb.pix_last);
      end
      tests_run++;
      if (busy_s !== 1'b0 || done_s !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
         tests_failed++; $display("FAIL reset_status: got busy=%0b done=%0b expected 0", busy_s, done_s);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (busy_s !== 1'b0 || dut_s.state_reg !== 3'd0) begin
         tests_failed++; $display("FAIL reset_idle: got busy=%0b state=%0d expected 0/0", busy_s, dut_s.state_reg);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_full_sweep();
      int nwords = 0, nreads = 0, done_cycle = -1, first_valid = -1;
      sb.pix_ready = 1'b1;
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int k = 1; k <= 200 && done_cycle < 0; k++) begin
         if (sb.mem_rd_en) begin
            tests_run++;
            if (sb.mem_addr !== 14'(nreads)) begin
               tests_failed++; $display("FAIL sweep_addr: got %0d expected %0d", sb.mem_addr, nreads);
            end
            nreads++;
         end
         if (sb.pix_valid && first_valid < 0) first_valid = k;
         if (sb.pix_valid && sb.pix_ready) begin
            $display("[TB] sweep word %0d data=%0h last=%0b", nwords, sb.pix_data, sb.pix_last);
            tests_run++;
            if (sb.pix_data !== 32'h100 + 32'(nwords) || sb.pix_last !== (nwords == 11)) begin
               tests_failed++; $display("FAIL sweep_word: got %0h last=%0b expected %0h last=%0b",
                                        sb.pix_data, sb.pix_last, 32'h100 + 32'(nwords), (nwords == 11));
            end
            nwords++;
         end
         if (done_s) done_cycle = k;
         @(negedge clk);
      end
      tests_run++;
      if (first_valid != 3) begin
         tests_failed++; $display("FAIL sweep_first_valid: got cycle %0d expected 3", first_valid);
      end
      tests_run++;
      if (nwords != 12 || nreads != 12) begin
         tests_failed++; $display("FAIL sweep_count: got words=%0d reads=%0d expected 12/12", nwords, nreads);
      end
      tests_run++;
      if (done_cycle != 37) begin
         tests_failed++; $display("FAIL sweep_done_cycle: got %0d expected 37", done_cycle);
      end
      tests_run++;
      if (busy_s !== 1'b0 || done_s !== 1'b0) begin
         tests_failed++; $display("FAIL sweep_after: got busy=%0b done=%0b expected 0/0", busy_s, done_s);
      end
   endtask

   task automatic test_row_wrap();
      int nreads = 0;
      bit done_seen = 0;
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int k = 1; k <= 200 && !done_seen; k++) begin
         if (sb.mem_rd_en) begin
            nreads++;
            if (nreads == 5) begin
               tests_run++;
               if (sb.mem_addr !== 14'd4 || dut_s.i_reg !== 2'd1 || dut_s.j_reg !== 2'd0) begin
                  tests_failed++; $display("FAIL row_wrap: got addr=%0d i=%0d j=%0d expected 4/1/0",
                                           sb.mem_addr, dut_s.i_reg, dut_s.j_reg);
               end
               $display("[TB] row wrap read addr=%0d", sb.mem_addr);
            end
         end
         if (done_s) done_seen = 1;
         @(negedge clk);
      end
      tests_run++;
      if (!done_seen) begin
         tests_failed++; $display("FAIL row_wrap_done: got no dump_done expected one");
      end
   endtask

   task automatic test_backpressure();
      int nwords = 0, nreads = 0, s = 0;
      bit done_seen = 0;
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int k = 1; k <= 200 && !done_seen; k++) begin
         if (sb.mem_rd_en) begin
            tests_run++;
            if (sb.mem_addr !== 14'(nreads)) begin
               tests_failed++; $display("FAIL bp_addr: got %0d expected %0d", sb.mem_addr, nreads);
            end
            nreads++;
         end
         if (sb.pix_valid && nwords == 2 && s <= 5) begin
            if (s == 0) begin
               sb.pix_ready = 1'b0;
            end else begin
               tests_run++;
               if (sb.pix_valid !== 1'b1 || sb.pix_data !== 32'h102 || sb.mem_rd_en !== 1'b0) begin
                  tests_failed++; $display("FAIL bp_hold: got v=%0b data=%0h rd=%0b expected 1/102/0",
                                           sb.pix_valid, sb.pix_data, sb.mem_rd_en);
               end
            end
            if (s == 5) sb.pix_ready = 1'b1;
            s++;
         end
         if (sb.pix_valid && sb.pix_ready) begin
            tests_run++;
            if (sb.pix_data !== 32'h100 + 32'(nwords)) begin
               tests_failed++; $display("FAIL bp_word: got %0h expected %0h", sb.pix_data, 32'h100 + 32'(nwords));
            end
            nwords++;
         end
         if (done_s) done_seen = 1;
         @(negedge clk);
      end
      sb.pix_ready = 1'b1;
      tests_run++;
      if (nwords != 12 || nreads != 12 || s != 6 || !done_seen) begin
         tests_failed++; $display("FAIL bp_totals: got words=%0d reads=%0d stalls=%0d done=%0b expected 12/12/6/1",
                                  nwords, nreads, s, done_seen);
      end
      $display("[TB] backpressure dump done");
   endtask

   task automatic test_reset_mid_dump();
      bit hit = 0, done_seen = 0;
      int ndone = 0, nreads = 0, nwords = 0;
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int k = 1; k <= 100 && !hit; k++) begin
         if (sb.pix_valid && sb.pix_data === 32'h106) hit = 1;
         else @(negedge clk);
      end
      tests_run++;
      if (!hit || dut_s.i_reg !== 2'd1 || dut_s.j_reg !== 2'd2) begin
         tests_failed++; $display("FAIL rmd_reach: got hit=%0b i=%0d j=%0d expected 1/1/2", hit, dut_s.i_reg, dut_s.j_reg);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (sb.mem_addr !== 14'd0 || sb.mem_rd_en !== 1'b0 || sb.pix_data !== 32'd0 ||
          sb.pix_valid !== 1'b0 || sb.pix_last !== 1'b0 || busy_s !== 1'b0 || done_s !== 1'b0) begin
         tests_failed++; $display("FAIL rmd_outputs: got addr=%0d rd=%0b data=%0h v=%0b busy=%0b expected all 0",
                                  sb.mem_addr, sb.mem_rd_en, sb.pix_data, sb.pix_valid, busy_s);
      end
      tests_run++;
      if (dut_s.state_reg !== 3'd0) begin
         tests_failed++; $display("FAIL rmd_state: got %0d expected 0", dut_s.state_reg);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (done_s || busy_s) ndone++;
         @(negedge clk);
      end
      tests_run++;
      if (ndone != 0) begin
         tests_failed++; $display("FAIL rmd_no_done: got %0d active cycles expected 0", ndone);
      end
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int k = 1; k <= 200 && !done_seen; k++) begin
         if (sb.mem_rd_en && nreads == 0) begin
            tests_run++;
            if (sb.mem_addr !== 14'd0) begin
               tests_failed++; $display("FAIL rmd_restart_addr: got %0d expected 0", sb.mem_addr);
            end
         end
         if (sb.mem_rd_en) nreads++;
         if (sb.pix_valid && sb.pix_ready && nwords == 0) begin
            tests_run++;
            if (sb.pix_data !== 32'h100) begin
               tests_failed++; $display("FAIL rmd_restart_word: got %0h expected 100", sb.pix_data);
            end
         end
         if (sb.pix_valid && sb.pix_ready) nwords++;
         if (done_s) done_seen = 1;
         @(negedge clk);
      end
      tests_run++;
      if (!done_seen || nwords != 12) begin
         tests_failed++; $display("FAIL rmd_restart_done: got done=%0b words=%0d expected 1/12", done_seen, nwords);
      end
      $display("[TB] reset mid-dump restart done");
   endtask

   task automatic test_start_while_busy();
      int ndone = 0, nreads = 0;
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         if (k == 10) start_s = 1'b1;
         if (k == 11) start_s = 1'b0;
         if (sb.mem_rd_en) nreads++;
         if (done_s) ndone++;
         @(negedge clk);
      end
      tests_run++;
      if (ndone != 1 || nreads != 12 || busy_s !== 1'b0) begin
         tests_failed++; $display("FAIL start_busy: got dones=%0d reads=%0d busy=%0b expected 1/12/0", ndone, nreads, busy_s);
      end
   endtask

   task automatic test_back_to_back();
      int d1 = -1, d2 = -1, ndone = 0;
      start_s = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 90; k++) begin
         if (done_s) begin
            ndone++;
            if (d1 < 0) d1 = k; else d2 = k;
         end
         if (k == 38) begin
            tests_run++;
            if (busy_s !== 1'b0 || dut_s.state_reg !== 3'd0) begin
               tests_failed++; $display("FAIL b2b_idle: got busy=%0b state=%0d expected 0/0", busy_s, dut_s.state_reg);
            end
         end
         if (k == 39) begin
            tests_run++;
            if (busy_s !== 1'b1 || sb.mem_rd_en !== 1'b1 || sb.mem_addr !== 14'd0) begin
               tests_failed++; $display("FAIL b2b_restart: got busy=%0b rd=%0b addr=%0d expected 1/1/0",
                                        busy_s, sb.mem_rd_en, sb.mem_addr);
            end
         end
         if (k == 40) start_s = 1'b0;
         @(negedge clk);
      end
      tests_run++;
      if (ndone != 2 || d1 != 37 || d2 != 75 || busy_s !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_dones: got n=%0d at %0d,%0d busy=%0b expected 2 at 37,75 busy 0",
                                  ndone, d1, d2, busy_b);
      end
      $display("[TB] back-to-back dumps done");
   endtask

   task automatic test_default_geometry();
      int nwords = 0, nreads = 0, seq_err = 0, done_cycle = -1;
      int last_addr = -1, max_addr = -1;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int k = 1; k <= 30100 && done_cycle < 0; k++) begin
         if (bb.mem_rd_en) begin
            if (bb.mem_addr !== 14'(nreads)) seq_err++;
            last_addr = int'(bb.mem_addr);
            if (last_addr > max_addr) max_addr = last_addr;
            nreads++;
         end
         if (bb.pix_valid && bb.pix_ready) begin
            if (nwords == 4207) begin
               tests_run++;
               if (bb.pix_data !== 32'hDEADBEEF) begin
                  tests_failed++; $display("FAIL geo_marker: got %0h expected deadbeef", bb.pix_data);
               end
               $display("[TB] geometry word 4207 data=%0h", bb.pix_data);
            end else if (bb.pix_data !== (32'h5000_0000 | 32'(nwords))) begin
               seq_err++;
            end
            nwords++;
         end
         if (done_b) done_cycle = k;
         @(negedge clk);
      end
      tests_run++;
      if (seq_err != 0 || nwords != 10000 || nreads != 10000) begin
         tests_failed++; $display("FAIL geo_sequence: got errs=%0d words=%0d reads=%0d expected 0/10000/10000",
                                  seq_err, nwords, nreads);
      end
      tests_run++;
      if (last_addr != 9999 || max_addr != 9999) begin
         tests_failed++; $display("FAIL geo_last_addr: got last=%0d max=%0d expected 9999/9999", last_addr, max_addr);
      end
      tests_run++;
      if (done_cycle != 30001) begin
         tests_failed++; $display("FAIL geo_done_cycle: got %0d expected 30001", done_cycle);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      clk          = 1'b0;
      rst          = 1'b1;
      start_s      = 1'b0;
      start_b      = 1'b0;
      sb.pix_ready = 1'b1;
      bb.pix_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      test_full_sweep();
      test_row_wrap();
      test_backpressure();
      test_reset_mid_dump();
      test_start_while_busy();
      test_back_to_back();
      test_default_geometry();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/ram_dump_reader.md
Name: ram_dump_reader

Overview:
Reader side of the processor data RAM. When the processor asserts f_done, this block takes over the RAM address and read-enable. It scans the result image in row-major order at address j + WIDTH*i and streams each 32-bit word out over a valid/ready interface. It sits beside Procesador and drives the RAM address mux while f_done is high.

Parameters:
WIDTH, 100, pixels per row (column count j)
HEIGHT, 100, rows (row count i)
ADDR_W, 14, RAM address width; WIDTH*HEIGHT must be at most 2^ADDR_W
DATA_W, 32, RAM word / output data width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start_dump  input  1  level or pulse; sampled in IDLE only (wired to f_done)
mem_addr  output  ADDR_W  RAM read address
mem_rd_en  output  1  RAM read strobe; gates RAM clock enable
mem_data  input  DATA_W  RAM read data, valid one cycle after the address edge
pix_data  output  DATA_W  streamed word
pix_valid  output  1  pix_data is valid
pix_ready  input  1  consumer accepts the word when pix_valid && pix_ready
pix_last  output  1  high with the final word (i=HEIGHT-1, j=WIDTH-1)
busy  output  1  high in every state except IDLE
dump_done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (asynchronous):
  - state=IDLE; i=j=0; row_base=0.
  - mem_addr=0, mem_rd_en=0, pix_data=0, pix_valid=0, pix_last=0, busy=0, dump_done=0.
  - Reset during a dump aborts it: no dump_done, and any pending word is dropped.
- FSM states: IDLE, ISSUE, WAIT, OUT, FINISH.
- IDLE:
  - When start_dump=1, clear i, j and row_base, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_rd_en=1 and mem_addr=row_base+j (registered outputs, valid during ISSUE).
  - Next state: WAIT.
- WAIT:
  - mem_rd_en=0. The RAM returns data during this cycle.
  - Capture mem_data into pix_data at the end of WAIT.
  - Set pix_last=(i==HEIGHT-1 && j==WIDTH-1).
  - Next state: OUT.
- OUT:
  - pix_valid=1. pix_data and pix_last stay stable until the transfer.
  - On a transfer (pix_ready=1), drop pix_valid next cycle, then:
    - if pix_last, go to FINISH;
    - else if j==WIDTH-1: j=0, i=i+1, row_base=row_base+WIDTH, go to ISSUE;
    - else j=j+1, go to ISSUE.
  - While pix_ready=0, hold in OUT indefinitely.
- FINISH:
  - dump_done=1 for exactly one cycle, busy=0 on the next cycle, return to IDLE.
- Address arithmetic:
  - The address is computed without a multiplier: row_base accumulates WIDTH per row.
  - row_base and the address are ADDR_W bits; the maximum address is WIDTH*HEIGHT-1, so there is no wrap.
- Throughput and latency:
  - With pix_ready held at 1, one word every 3 cycles.
  - First pix_valid appears 3 cycles after the start_dump sample edge.
  - A full dump takes 3*WIDTH*HEIGHT+1 cycles from start to dump_done.
- start_dump is ignored while busy=1. If start_dump is still high on the IDLE cycle after FINISH, a new dump begins.
- mem_rd_en is asserted only in ISSUE, so the RAM sees exactly one read per word.

Test Plan:
- Reset mid-dump:
  - Stimulus: WIDTH=4, HEIGHT=3; assert rst while in OUT at i=1, j=2.
  - Required: all outputs 0 immediately, state IDLE, no dump_done; the next start_dump restarts at address 0.
- Full sweep, pix_ready=1:
  - Stimulus: WIDTH=4, HEIGHT=3, RAM preloaded with word[a]=a+0x100.
  - Required: 12 words 0x100..0x10B in order.
  - Required: mem_addr sequence 0,1,2,…,11.
  - Required: pix_last only on 0x10B; dump_done at cycle 37 after start.
- Default geometry:
  - Stimulus: WIDTH=100, HEIGHT=100; RAM word at 7+100*42=4207 set to 0xDEADBEEF.
  - Required: that value is streamed as word index 4207.
  - Required: the last mem_addr is 9999, with no address above 9999.
- Backpressure:
  - Stimulus: hold pix_ready=0 for 5 cycles on word 2.
  - Required: pix_data and pix_valid stay stable for all 5 cycles; no extra mem_rd_en pulses; the sequence resumes intact.
- Row wrap:
  - Stimulus: WIDTH=4; check the transition from j=3, i=0.
  - Required: the next mem_addr=4, with i=1, j=0.
- Start while busy:
  - Stimulus: pulse start_dump mid-dump.
  - Required: ignored; exactly one dump_done.
  - Stimulus: hold start_dump high continuously.
  - Required: back-to-back dumps with one IDLE cycle between them.
